// File: rtl/mc14500_pkg.sv
// Shared opcode encodings, PC-update selector and instruction-field helpers
// for the MC14500 program sequencer.
package mc14500_pkg;

  // Widest instruction word the helpers accept: 4-bit opcode + 32-bit operand.
  localparam int MAXW = 36;

  localparam logic [3:0] OP_NOPO = 4'b0000;
  localparam logic [3:0] OP_LD   = 4'b0001;
  localparam logic [3:0] OP_LDC  = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_ANDC = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_ORC  = 4'b0110;
  localparam logic [3:0] OP_XNOR = 4'b0111;
  localparam logic [3:0] OP_STO  = 4'b1000;
  localparam logic [3:0] OP_STOC = 4'b1001;
  localparam logic [3:0] OP_IEN  = 4'b1010;
  localparam logic [3:0] OP_OEN  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RTN  = 4'b1101;
  localparam logic [3:0] OP_SKZ  = 4'b1110;
  localparam logic [3:0] OP_NOPF = 4'b1111;

  typedef enum logic [2:0] {
    PC_INC,
    PC_SCAN,
    PC_JMP,
    PC_RTN,
    PC_CALL
  } pc_sel_e;

  // Opcode sits directly above an aw-bit operand.
  function automatic logic [3:0] opc(input logic [MAXW-1:0] w, input int aw);
    logic [MAXW-1:0] t;
    t = w >> aw;
    return t[3:0];
  endfunction

  function automatic logic [MAXW-1:0] opr(input logic [MAXW-1:0] w, input int aw);
    return w & ~({MAXW{1'b1}} << aw);
  endfunction

endpackage

// File: rtl/mc14500_rstack.sv
// Circular return-address LIFO; pushing when full overwrites the oldest entry.
module mc14500_rstack
  import mc14500_pkg::*;
#(
  parameter int SD = 4,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] dout,
  output logic          empty,
  output logic          full
);

  localparam int PW = (SD > 1) ? $clog2(SD) : 1;
  localparam logic [PW-1:0] PONE = 1;
  localparam logic [PW:0]   CONE = 1;
  localparam logic [PW:0]   CAP  = (PW+1)'(SD);

  logic [AW-1:0] mem [SD];
  logic [PW-1:0] sp;
  logic [PW:0]   cnt;

  assign empty = (cnt == '0);
  assign full  = (cnt == CAP);
  assign dout  = mem[sp - PONE];

  always_ff @(posedge clk) begin
    if (push) mem[sp] <= din;
  end

  // Count saturates at SD so an overflowed stack still reports full, not empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp  <= '0;
      cnt <= '0;
    end else if (push) begin
      sp <= sp + PONE;
      if (!full) cnt <= cnt + CONE;
    end else if (pop && !empty) begin
      sp  <= sp - PONE;
      cnt <= cnt - CONE;
    end
  end

endmodule

// File: rtl/mc14500_seq.sv
// MC14500 program sequencer: PC/return stack driven by ICU flags, and the
// 1-bit io_d responder over synchronized inputs and readable output latches.
module mc14500_seq
  import mc14500_pkg::*;
#(
  parameter int AW  = 8,
  parameter int IOW = 3,
  parameter int SD  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  output logic [AW-1:0]         prog_addr,
  input  logic [3+AW:0]         prog_data,
  output logic [3:0]            icu_i,
  input  logic                  icu_write,
  input  logic                  icu_jmp,
  input  logic                  icu_rtn,
  input  logic                  icu_flg0,
  input  logic                  icu_flgf,
  inout  wire                   io_d,
  input  logic [(1<<IOW)-1:0]   in_pins,
  output logic [(1<<IOW)-1:0]   out_pins,
  output logic                  scan_done,
  output logic                  stk_err
);

  localparam logic [AW-1:0] AONE = 1;

  logic [AW-1:0]        pc, pc_inc, operand, stk_dout;
  logic [3:0]           opcode;
  logic                 sel, rd_val, drive, call_pending;
  logic [IOW-1:0]       idx;
  logic [(1<<IOW)-1:0]  sync1, in_sync;
  logic                 push, pop, stk_empty, stk_full;
  pc_sel_e              psel;

  assign opcode    = opc(MAXW'(prog_data), AW);
  assign operand   = AW'(opr(MAXW'(prog_data), AW));
  assign prog_addr = pc;
  assign pc_inc    = pc + AONE;
  assign icu_i     = run ? opcode : OP_NOPO;

  assign sel    = operand[IOW];
  assign idx    = operand[IOW-1:0];
  assign rd_val = sel ? out_pins[idx] : in_sync[idx];
  // The ICU owns io_d while it stores.
  assign drive  = run && (opcode != OP_STO) && (opcode != OP_STOC);
  assign io_d   = drive ? rd_val : 1'bz;

  always_comb begin
    psel = PC_INC;
    if      (icu_flg0) psel = PC_SCAN;
    else if (icu_jmp)  psel = PC_JMP;
    else if (icu_rtn)  psel = PC_RTN;
    else if (icu_flgf) psel = PC_CALL;
  end

  assign push = run && (psel == PC_JMP) && call_pending;
  assign pop  = run && (psel == PC_RTN) && !stk_empty;

  mc14500_rstack #(.SD(SD), .AW(AW)) u_rstack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (stk_dout),
    .empty (stk_empty),
    .full  (stk_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= '0;
      call_pending <= 1'b0;
      scan_done    <= 1'b0;
      stk_err      <= 1'b0;
      out_pins     <= '0;
      sync1        <= '0;
      in_sync      <= '0;
    end else begin
      sync1     <= in_pins;
      in_sync   <= sync1;
      scan_done <= 1'b0;
      if (run) begin
        case (psel)
          PC_SCAN: begin
            pc           <= '0;
            scan_done    <= 1'b1;
            call_pending <= 1'b0;
          end
          PC_JMP: begin
            pc <= operand;
            if (call_pending) begin
              call_pending <= 1'b0;
              if (stk_full) stk_err <= 1'b1;
            end
          end
          PC_RTN: begin
            if (!stk_empty) pc <= stk_dout;
            else begin
              stk_err <= 1'b1;
              pc      <= pc_inc;
            end
          end
          PC_CALL: begin
            call_pending <= 1'b1;
            pc           <= pc_inc;
          end
          default: pc <= pc_inc;
        endcase
        if (icu_write && sel) out_pins[idx] <= io_d;
      end
    end
  end

endmodule

// File: tb/tb_mc14500_seq.sv
// Directed bench for mc14500_seq: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_mc14500_seq;
  import mc14500_pkg::*;

  localparam int AW = 8, IOW = 3, SD = 4;

  logic        clk = 1'b0, rst = 1'b1, run = 1'b0;
  logic [7:0]  prog_addr;
  logic [11:0] prog_data;
  logic [3:0]  icu_i;
  logic        icu_write, icu_jmp, icu_rtn, icu_flg0, icu_flgf;
  wire         io_d;
  logic [7:0]  in_pins = '0;
  logic [7:0]  out_pins;
  logic        scan_done, stk_err;
  logic        tb_val = 1'b0;
  logic [11:0] rom [256];

  always #5 clk = ~clk;

  // The bench plays the ICU: flags decode from the opcode it is shown.
  assign prog_data = rom[prog_addr];
  assign icu_write = (icu_i == OP_STO) || (icu_i == OP_STOC);
  assign icu_jmp   = (icu_i == OP_JMP);
  assign icu_rtn   = (icu_i == OP_RTN);
  assign icu_flg0  = (icu_i == OP_NOPO);
  assign icu_flgf  = (icu_i == OP_NOPF);
  assign io_d      = icu_write ? tb_val : 1'bz;

  mc14500_seq #(.AW(AW), .IOW(IOW), .SD(SD)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .icu_i     (icu_i),
    .icu_write (icu_write),
    .icu_jmp   (icu_jmp),
    .icu_rtn   (icu_rtn),
    .icu_flg0  (icu_flg0),
    .icu_flgf  (icu_flgf),
    .io_d      (io_d),
    .in_pins   (in_pins),
    .out_pins  (out_pins),
    .scan_done (scan_done),
    .stk_err   (stk_err)
  );

  typedef struct {
    string      nm;
    logic [7:0] pc;
    logic [3:0] ii;
    bit         ci;
    logic       io;
    logic [7:0] op;
    logic       sd;
    logic       er;
  } exp_t;

  exp_t  sb[$];
  int    n_cmp = 0, n_bad = 0;
  string tname = "none";

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if (prog_addr !== e.pc || icu_i !== e.ii || (e.ci && io_d !== e.io) ||
          out_pins !== e.op || scan_done !== e.sd || stk_err !== e.er) begin
        n_bad++;
        $display("FAIL %s: got pc=%h i=%h io=%b out=%h sd=%b err=%b, want pc=%h i=%h io=%b(chk=%0d) out=%h sd=%b err=%b",
                 e.nm, prog_addr, icu_i, io_d, out_pins, scan_done, stk_err,
                 e.pc, e.ii, e.io, e.ci, e.op, e.sd, e.er);
      end
    end
  end

  // Expect the currently visible state, then advance one clock.
  task automatic chk(input logic [7:0] pc, input logic [3:0] ii, input bit ci,
                     input logic io, input logic [7:0] op, input logic sd, input logic er);
    exp_t e;
    e.nm = tname; e.pc = pc; e.ii = ii; e.ci = ci; e.io = io;
    e.op = op; e.sd = sd; e.er = er;
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic clr();
    for (int i = 0; i < 256; i++) rom[i] = 12'h100;
  endtask

  initial begin
    // Reset, then a linear scan of LD 0x00 with an input edge on pin 0.
    clr();
    do_reset();
    tname = "reset";
    chk(8'h00, 4'h0, 0, 1'b0, 8'h00, 1'b0, 1'b0);
    run = 1'b1;
    tname = "count";
    chk(8'h00, 4'h1, 1, 1'b0, 8'h00, 1'b0, 1'b0);
    in_pins = 8'h01;
    tname = "sync_lat";
    chk(8'h01, 4'h1, 1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk(8'h02, 4'h1, 1, 1'b0, 8'h00, 1'b0, 1'b0);
    chk(8'h03, 4'h1, 1, 1'b1, 8'h00, 1'b0, 1'b0);
    chk(8'h04, 4'h1, 1, 1'b1, 8'h00, 1'b0, 1'b0);

    // I/O: input read, stores, readback, ignored sel=0 store, STOC.
    clr();
    rom[0] = 12'h103; rom[1] = 12'h80A; rom[2] = 12'h80B;
    rom[3] = 12'h10A; rom[4] = 12'h802; rom[5] = 12'h90A;
    in_pins = 8'h08;
    do_reset();
    tname = "settle";
    chk(8'h00, 4'h0, 0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk(8'h00, 4'h0, 0, 1'b0, 8'h00, 1'b0, 1'b0);
    run = 1'b1;
    tname = "ld_in3";
    chk(8'h00, 4'h1, 1, 1'b1, 8'h00, 1'b0, 1'b0);
    tb_val = 1'b1;
    tname = "sto_0a";
    chk(8'h01, 4'h8, 0, 1'b0, 8'h00, 1'b0, 1'b0);
    tname = "sto_0b";
    chk(8'h02, 4'h8, 0, 1'b0, 8'h04, 1'b0, 1'b0);
    tname = "readback";
    chk(8'h03, 4'h1, 1, 1'b1, 8'h0C, 1'b0, 1'b0);
    tname = "sto_sel0";
    chk(8'h04, 4'h8, 0, 1'b0, 8'h0C, 1'b0, 1'b0);
    tb_val = 1'b0;
    tname = "stoc_0a";
    chk(8'h05, 4'h9, 0, 1'b0, 8'h0C, 1'b0, 1'b0);
    tname = "after_stoc";
    chk(8'h06, 4'h1, 1, 1'b0, 8'h08, 1'b0, 1'b0);

    // Call/return, then a return with an empty stack.
    clr();
    rom[0] = 12'hF00; rom[1] = 12'hC40; rom[8'h40] = 12'hD00; rom[2] = 12'hD00;
    do_reset();
    run = 1'b1;
    tname = "call";
    chk(8'h00, 4'hF, 0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk(8'h01, 4'hC, 0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk(8'h40, 4'hD, 0, 1'b0, 8'h00, 1'b0, 1'b0);
    tname = "ret";
    chk(8'h02, 4'hD, 0, 1'b0, 8'h00, 1'b0, 1'b0);
    tname = "ret_empty";
    chk(8'h03, 4'h1, 0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Plain jump pushes nothing; RTN underflows.
    clr();
    rom[0] = 12'hC20; rom[8'h20] = 12'hD00;
    do_reset();
    run = 1'b1;
    tname = "jmp_plain";
    chk(8'h00, 4'hC, 0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk(8'h20, 4'hD, 0, 1'b0, 8'h00, 1'b0, 1'b0);
    tname = "underflow";
    chk(8'h21, 4'h1, 0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Five nested calls into a depth-4 stack, then four returns.
    clr();
    for (int k = 0; k < 5; k++) begin
      rom[16*k]   = 12'hF00;
      rom[16*k+1] = {4'hC, 8'(16*k+16)};
    end
    rom[8'h50] = 12'hD00; rom[8'h42] = 12'hD00;
    rom[8'h32] = 12'hD00; rom[8'h22] = 12'hD00;
    do_reset();
    run = 1'b1;
    tname = "nest_call";
    for (int k = 0; k < 5; k++) begin
      chk(8'(16*k),   4'hF, 0, 1'b0, 8'h00, 1'b0, 1'b0);
      chk(8'(16*k+1), 4'hC, 0, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    tname = "overflow";
    chk(8'h50, 4'hD, 0, 1'b0, 8'h00, 1'b0, 1'b1);
    tname = "nest_ret";
    chk(8'h42, 4'hD, 0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk(8'h32, 4'hD, 0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk(8'h22, 4'hD, 0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk(8'h12, 4'h1, 0, 1'b0, 8'h00, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tname = "rst_over_run";
    chk(8'h00, 4'hF, 0, 1'b0, 8'h00, 1'b0, 1'b0);

    // run low freezes the PC at a NOPO; releasing it restarts the scan.
    clr();
    rom[0] = 12'hC10; rom[8'h10] = 12'h000;
    do_reset();
    run = 1'b1;
    tname = "to_nopo";
    chk(8'h00, 4'hC, 0, 1'b0, 8'h00, 1'b0, 1'b0);
    run = 1'b0;
    tname = "hold";
    chk(8'h10, 4'h0, 0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk(8'h10, 4'h0, 0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk(8'h10, 4'h0, 0, 1'b0, 8'h00, 1'b0, 1'b0);
    run = 1'b1;
    tname = "nopo";
    chk(8'h10, 4'h0, 0, 1'b0, 8'h00, 1'b0, 1'b0);
    tname = "scan_done";
    chk(8'h00, 4'hC, 0, 1'b0, 8'h00, 1'b1, 1'b0);
    tname = "scan_pulse";
    chk(8'h10, 4'h0, 0, 1'b0, 8'h00, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
